// File: rtl/cpu_pkg.sv
// Shared CPU control constants: phase names and default sequencer sizing.
package cpu_pkg;

  // Named phases of the classic four-phase instruction cycle.
  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_WB     = 3;

  // Default number of phases per instruction and retired-count width.
  localparam int DEF_NPHASE = 4;
  localparam int DEF_CNT_W  = 16;

endpackage : cpu_pkg

// File: rtl/event_counter.sv
// Wrap-around event counter with synchronous clear and increment enable.
module event_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count register: clear wins, otherwise step by one and wrap modulo 2^CNT_W.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : event_counter

// File: rtl/phase_sequencer.sv
// Multi-cycle phase index generator for the CPU control unit.
// Stall, early restart, direct phase load, completion pulse and a retired
// instruction counter. Define PHASE_SEQ_ONEHOT_EN to add a registered one-hot
// copy of the phase (phase_oh).
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter  int NPHASE = DEF_NPHASE,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int W      = $clog2(NPHASE)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  output logic [W-1:0]     phase,
  output logic             last,
  output logic             done,
  output logic [CNT_W-1:0] insn_cnt,
  output logic             bad_load
`ifdef PHASE_SEQ_ONEHOT_EN
  ,
  output logic [NPHASE-1:0] phase_oh
`endif
);

  // Final legal phase; the wrap point even when NPHASE is not a power of 2.
  localparam logic [W-1:0] LAST_PH  = W'(NPHASE - 1);
  localparam logic [W-1:0] FIRST_PH = W'(PH_FETCH);
  // NPHASE widened by one bit so the range check on load_val cannot overflow.
  localparam logic [W:0]   NPHASE_X = (W + 1)'(NPHASE);

  logic [W-1:0] next_phase;
  logic         next_done;
  logic         next_bad;
  logic         complete;
  logic         load_ok;

  assign load_ok = ({1'b0, load_val} < NPHASE_X);

  // Next-state priority mux: load > restart > en; clear is applied in the registers.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_phase = phase;
    next_done  = 1'b0;
    next_bad   = bad_load;
    complete   = 1'b0;
    if (load) begin
      if (load_ok) begin
        next_phase = load_val;
      end else begin
        next_bad = 1'b1;
      end
    end else if (restart) begin
      next_phase = FIRST_PH;
      next_done  = 1'b1;
      complete   = 1'b1;
    end else if (en) begin
      if (phase == LAST_PH) begin
        next_phase = FIRST_PH;
        next_done  = 1'b1;
        complete   = 1'b1;
      end else begin
        next_phase = phase + W'(1);
      end
    end
  end

  // Phase, completion pulse and sticky bad-load flag registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      phase    <= FIRST_PH;
      done     <= 1'b0;
      bad_load <= 1'b0;
    end else begin
      phase    <= next_phase;
      done     <= next_done;
      bad_load <= next_bad;
    end
  end

  assign last = (phase == LAST_PH);

  // Retired-instruction counter; clear discards any partial instruction.
  event_counter #(
    .CNT_W (CNT_W)
  ) u_insn_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (complete),
    .count (insn_cnt)
  );

`ifdef PHASE_SEQ_ONEHOT_EN
  logic [NPHASE-1:0] next_oh;

  // One-hot decode of the next phase, registered so it tracks phase exactly.
  always_comb begin
    next_oh             = '0;
    next_oh[next_phase] = 1'b1;
  end

  // One-hot phase register; reset value is bit 0 (phase 0).
  always_ff @(posedge clk) begin
    if (clear) begin
      phase_oh <= NPHASE'(1);
    end else begin
      phase_oh <= next_oh;
    end
  end
`else
  // One-hot phase output is not built in this configuration.
`endif

endmodule : phase_sequencer

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer.
// dut_a: NPHASE=4, CNT_W=16. dut_b: NPHASE=5, CNT_W=2.
module tb_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // dut_a signals
  logic        clear_a, en_a, restart_a, load_a;
  logic [1:0]  load_val_a, phase_a;
  logic        last_a, done_a, bad_a;
  logic [15:0] cnt_a;
  // dut_b signals
  logic        clear_b, en_b, restart_b, load_b;
  logic [2:0]  load_val_b, phase_b;
  logic        last_b, done_b, bad_b;
  logic [1:0]  cnt_b;
`ifdef PHASE_SEQ_ONEHOT_EN
  logic [3:0]  oh_a;
  logic [4:0]  oh_b;
`endif

  phase_sequencer #(.NPHASE(4), .CNT_W(16)) dut_a (
    .clk      (clk),
    .clear    (clear_a),
    .en       (en_a),
    .restart  (restart_a),
    .load     (load_a),
    .load_val (load_val_a),
    .phase    (phase_a),
    .last     (last_a),
    .done     (done_a),
    .insn_cnt (cnt_a),
    .bad_load (bad_a)
`ifdef PHASE_SEQ_ONEHOT_EN
    ,
    .phase_oh (oh_a)
`endif
  );

  phase_sequencer #(.NPHASE(5), .CNT_W(2)) dut_b (
    .clk      (clk),
    .clear    (clear_b),
    .en       (en_b),
    .restart  (restart_b),
    .load     (load_b),
    .load_val (load_val_b),
    .phase    (phase_b),
    .last     (last_b),
    .done     (done_b),
    .insn_cnt (cnt_b),
    .bad_load (bad_b)
`ifdef PHASE_SEQ_ONEHOT_EN
    ,
    .phase_oh (oh_b)
`endif
  );

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_a = 1'b1; en_a = 1'b0; restart_a = 1'b0; load_a = 1'b0; load_val_a = '0;
    clear_b = 1'b1; en_b = 1'b0; restart_b = 1'b0; load_b = 1'b0; load_val_b = '0;
    step();
    total++; if (phase_a !== 2'd0) begin bad++; $display("FAIL reset_phase_a got=%0d exp=0", phase_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done_a got=%b exp=0", done_a); end
    total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL reset_cnt_a got=%0d exp=0", cnt_a); end
    total++; if (bad_a !== 1'b0) begin bad++; $display("FAIL reset_bad_a got=%b exp=0", bad_a); end
    total++; if (last_a !== 1'b0) begin bad++; $display("FAIL reset_last_a got=%b exp=0", last_a); end
    total++; if (phase_b !== 3'd0) begin bad++; $display("FAIL reset_phase_b got=%0d exp=0", phase_b); end
    total++; if (cnt_b !== 2'd0) begin bad++; $display("FAIL reset_cnt_b got=%0d exp=0", cnt_b); end
`ifdef PHASE_SEQ_ONEHOT_EN
    total++; if (oh_a !== 4'b0001) begin bad++; $display("FAIL reset_oh_a got=%b exp=0001", oh_a); end
`endif
    clear_a = 1'b0;
    clear_b = 1'b0;
  endtask

  task automatic test_free_run();
    logic [1:0] ep;
    logic       ed;
    en_a = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      ep = 2'(i % 4);
      ed = (i % 4 == 0);
      total++; if (phase_a !== ep) begin bad++; $display("FAIL run_phase step=%0d got=%0d exp=%0d", i, phase_a, ep); end
      total++; if (done_a !== ed) begin bad++; $display("FAIL run_done step=%0d got=%b exp=%b", i, done_a, ed); end
      total++; if (last_a !== (ep == 2'd3)) begin bad++; $display("FAIL run_last step=%0d got=%b exp=%b", i, last_a, ep == 2'd3); end
`ifdef PHASE_SEQ_ONEHOT_EN
      total++; if (oh_a !== (4'b0001 << ep)) begin bad++; $display("FAIL run_oh step=%0d got=%b exp=%b", i, oh_a, 4'b0001 << ep); end
`endif
    end
    total++; if (cnt_a !== 16'd2) begin bad++; $display("FAIL run_cnt got=%0d exp=2", cnt_a); end
  endtask

  task automatic test_stall();
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (phase_a !== 2'd2) begin bad++; $display("FAIL stall_phase cyc=%0d got=%0d exp=2", i, phase_a); end
      total++; if (done_a !== 1'b0) begin bad++; $display("FAIL stall_done cyc=%0d got=%b exp=0", i, done_a); end
    end
    en_a = 1'b1;
    step();
    total++; if (phase_a !== 2'd3) begin bad++; $display("FAIL stall_resume3 got=%0d exp=3", phase_a); end
    step();
    total++; if (phase_a !== 2'd0) begin bad++; $display("FAIL stall_resume0 got=%0d exp=0", phase_a); end
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL stall_done_wrap got=%b exp=1", done_a); end
    total++; if (cnt_a !== 16'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", cnt_a); end
  endtask

  task automatic test_restart();
    step();
    total++; if (phase_a !== 2'd1) begin bad++; $display("FAIL rst_pre_phase got=%0d exp=1", phase_a); end
    restart_a = 1'b1; en_a = 1'b0;
    step();
    total++; if (phase_a !== 2'd0) begin bad++; $display("FAIL restart_phase got=%0d exp=0", phase_a); end
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL restart_done got=%b exp=1", done_a); end
    total++; if (cnt_a !== 16'd4) begin bad++; $display("FAIL restart_cnt got=%0d exp=4", cnt_a); end
    // Back-to-back restart while already at phase 0 still retires one.
    step();
    total++; if (phase_a !== 2'd0) begin bad++; $display("FAIL b2b_phase got=%0d exp=0", phase_a); end
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done_a); end
    total++; if (cnt_a !== 16'd5) begin bad++; $display("FAIL b2b_cnt got=%0d exp=5", cnt_a); end
    restart_a = 1'b0;
    step();
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL idle_done got=%b exp=0", done_a); end
    restart_a = 1'b1; load_a = 1'b1; load_val_a = 2'd2;
    step();
    total++; if (phase_a !== 2'd2) begin bad++; $display("FAIL loadwin_phase got=%0d exp=2", phase_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL loadwin_done got=%b exp=0", done_a); end
    total++; if (cnt_a !== 16'd5) begin bad++; $display("FAIL loadwin_cnt got=%0d exp=5", cnt_a); end
    load_val_a = 2'd0;
    step();
    total++; if (phase_a !== 2'd0) begin bad++; $display("FAIL load0_phase got=%0d exp=0", phase_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL load0_done got=%b exp=0", done_a); end
    total++; if (cnt_a !== 16'd5) begin bad++; $display("FAIL load0_cnt got=%0d exp=5", cnt_a); end
    restart_a = 1'b0; load_a = 1'b0;
  endtask

  task automatic test_load();
    load_a = 1'b1; load_val_a = 2'd3;
    step();
    total++; if (phase_a !== 2'd3) begin bad++; $display("FAIL load3_phase got=%0d exp=3", phase_a); end
    total++; if (last_a !== 1'b1) begin bad++; $display("FAIL load3_last got=%b exp=1", last_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL load3_done got=%b exp=0", done_a); end
    load_a = 1'b0; en_a = 1'b1;
    step();
    total++; if (phase_a !== 2'd0) begin bad++; $display("FAIL load3_wrap got=%0d exp=0", phase_a); end
    total++; if (cnt_a !== 16'd6) begin bad++; $display("FAIL load3_cnt got=%0d exp=6", cnt_a); end
    en_a = 1'b0;
    // Out-of-range loads on the NPHASE=5 instance.
    en_b = 1'b1;
    step();
    step();
    load_b = 1'b1; load_val_b = 3'd6; restart_b = 1'b1;
    step();
    total++; if (phase_b !== 3'd2) begin bad++; $display("FAIL badload_phase got=%0d exp=2", phase_b); end
    total++; if (bad_b !== 1'b1) begin bad++; $display("FAIL badload_flag got=%b exp=1", bad_b); end
    total++; if (done_b !== 1'b0) begin bad++; $display("FAIL badload_done got=%b exp=0", done_b); end
    load_b = 1'b0; restart_b = 1'b0; en_b = 1'b0;
    step();
    step();
    total++; if (bad_b !== 1'b1) begin bad++; $display("FAIL badload_sticky got=%b exp=1", bad_b); end
    total++; if (phase_b !== 3'd2) begin bad++; $display("FAIL badload_hold got=%0d exp=2", phase_b); end
    load_b = 1'b1; load_val_b = 3'd4;
    step();
    total++; if (phase_b !== 3'd4) begin bad++; $display("FAIL load4_phase got=%0d exp=4", phase_b); end
    total++; if (last_b !== 1'b1) begin bad++; $display("FAIL load4_last got=%b exp=1", last_b); end
    load_val_b = 3'd5;
    step();
    total++; if (phase_b !== 3'd4) begin bad++; $display("FAIL load5_phase got=%0d exp=4", phase_b); end
    load_b = 1'b0; clear_b = 1'b1;
    step();
    total++; if (bad_b !== 1'b0) begin bad++; $display("FAIL badload_clear got=%b exp=0", bad_b); end
    total++; if (phase_b !== 3'd0) begin bad++; $display("FAIL clear_b_phase got=%0d exp=0", phase_b); end
    clear_b = 1'b0;
  endtask

  task automatic test_wrap5();
    logic [2:0] ep;
    logic [1:0] ec;
    logic       ed;
    en_b = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      ep = 3'(k % 5);
      ec = 2'((k / 5) % 4);
      ed = (k % 5 == 0);
      total++; if (phase_b !== ep) begin bad++; $display("FAIL wrap5_phase step=%0d got=%0d exp=%0d", k, phase_b, ep); end
      total++; if (cnt_b !== ec) begin bad++; $display("FAIL wrap5_cnt step=%0d got=%0d exp=%0d", k, cnt_b, ec); end
      total++; if (done_b !== ed) begin bad++; $display("FAIL wrap5_done step=%0d got=%b exp=%b", k, done_b, ed); end
    end
    en_b = 1'b0;
  endtask

  task automatic test_clear();
    en_a = 1'b1;
    step();
    step();
    total++; if (phase_a !== 2'd2) begin bad++; $display("FAIL clr_pre_phase got=%0d exp=2", phase_a); end
    clear_a = 1'b1; load_a = 1'b1; load_val_a = 2'd3; restart_a = 1'b1;
    step();
    total++; if (phase_a !== 2'd0) begin bad++; $display("FAIL clr_phase got=%0d exp=0", phase_a); end
    total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", cnt_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL clr_done got=%b exp=0", done_a); end
`ifdef PHASE_SEQ_ONEHOT_EN
    total++; if (oh_a !== 4'b0001) begin bad++; $display("FAIL clr_oh got=%b exp=0001", oh_a); end
`endif
    clear_a = 1'b0; load_a = 1'b0; restart_a = 1'b0; en_a = 1'b0;
    step();
    total++; if (phase_a !== 2'd0) begin bad++; $display("FAIL clr_after_phase got=%0d exp=0", phase_a); end
    total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL clr_after_cnt got=%0d exp=0", cnt_a); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_restart();
    test_load();
    test_wrap5();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_phase_sequencer
